// File: rtl/status_capture_reg.sv
// Status capture register: per-bit sticky/transparent status with CPU read/clear and masked interrupt.
// Latency: read data and rd_valid appear one edge after the read; interrupt follows stat_q by one edge.
// Backpressure: none; the CPU may read or write every cycle, and every read gets its own rd_valid pulse.
module status_capture_reg #(
    parameter int         NumInputs    = 8,
    parameter logic [7:0] StickyMask   = 8'h00,
    parameter logic [7:0] IntrMaskInit = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       status_0,
    input  logic       status_1,
    input  logic       status_2,
    input  logic       status_3,
    input  logic       status_4,
    input  logic       status_5,
    input  logic       status_6,
    input  logic       status_7,
    input  logic       addr,
    input  logic       rd_en,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       interrupt
);

    // Out-of-range parameter values are clamped so the valid-bit mask stays meaningful.
    localparam int NumEff = (NumInputs > 8) ? 8 : ((NumInputs < 1) ? 1 : NumInputs);

    // Bits at or above NumEff do not exist: they are forced to zero everywhere.
    localparam logic [7:0] ValidMask = 8'((16'h0001 << NumEff) - 16'h0001);

    // Register-select encodings for the CPU port.
    localparam logic AddrStatus = 1'b0;
    localparam logic AddrMask   = 1'b1;

    logic [7:0] status_in;
    logic       rd_stat;
    logic       rd_mask;
    logic       wr_mask;

    logic [7:0] stat_q,     stat_d;
    logic [7:0] mask_q,     mask_d;
    logic [7:0] rd_data_q,  rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       intr_q,     intr_d;

    // The scalar status pins are gathered into one vector; unused bits are dropped here.
    assign status_in = {status_7, status_6, status_5, status_4,
                        status_3, status_2, status_1, status_0} & ValidMask;

    // A status read is the only thing that clears sticky bits.
    // Writes to the status address have no decode and are therefore ignored.
    assign rd_stat = rd_en && (addr == AddrStatus);
    assign rd_mask = rd_en && (addr == AddrMask);
    assign wr_mask = wr_en && (addr == AddrMask);

    // Status next state: transparent bits follow the pin, sticky bits accumulate
    // and are cleared by a status read, except that a pin high in the same cycle wins.
    always_comb begin
        stat_d = '0;
        for (int i = 0; i < 8; i++) begin
            if (ValidMask[i]) begin
                if (StickyMask[i]) begin
                    stat_d[i] = status_in[i] | (stat_q[i] & ~rd_stat);
                end else begin
                    stat_d[i] = status_in[i];
                end
            end
        end
    end

    // Mask next state: only a write to the mask address loads it.
    always_comb begin
        mask_d = mask_q;
        if (wr_mask) begin
            mask_d = wr_data & ValidMask;
        end
    end

    // Read path: capture the pre-edge register value, so a read that coincides with a write
    // returns the old mask. rd_data holds between reads.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rd_stat) begin
            rd_data_d  = stat_q;
            rd_valid_d = 1'b1;
        end else if (rd_mask) begin
            rd_data_d  = mask_q;
            rd_valid_d = 1'b1;
        end
    end

    // Interrupt is a registered OR of the enabled captured bits, one edge behind stat_q/mask_q.
    always_comb begin
        intr_d = |(stat_q & mask_q);
    end

    // State registers; reset overrides every request in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_q     <= '0;
            mask_q     <= IntrMaskInit & ValidMask;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            intr_q     <= 1'b0;
        end else begin
            stat_q     <= stat_d;
            mask_q     <= mask_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            intr_q     <= intr_d;
        end
    end

    // Every output comes straight from a flop.
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign interrupt = intr_q;

endmodule
